// File: rtl/tcp_tx_arbiter.sv
// Arbitrates NUM_SOCKETS TCP transmit engines onto one packet generator: latch header, strobe, stream payload.
// Define TCP_TX_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module tcp_tx_arbiter #(
  parameter int NUM_SOCKETS = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_SOCKETS-1:0]            i_req,
  input  logic [NUM_SOCKETS-1:0]            i_has_payload,
  input  logic [32*NUM_SOCKETS-1:0]         i_seq_number,
  input  logic [32*NUM_SOCKETS-1:0]         i_ack_number,
  input  logic [16*NUM_SOCKETS-1:0]         i_source_port,
  input  logic [16*NUM_SOCKETS-1:0]         i_dest_port,
  input  logic [8*NUM_SOCKETS-1:0]          i_flags,
  input  logic [16*NUM_SOCKETS-1:0]         i_window_size,
  input  logic [32*NUM_SOCKETS-1:0]         i_dst_ip,
  input  logic [DATA_WIDTH*NUM_SOCKETS-1:0] s_axis_tdata,
  input  logic [NUM_SOCKETS-1:0]            s_axis_tvalid,
  input  logic [NUM_SOCKETS-1:0]            s_axis_tlast,
  output logic [NUM_SOCKETS-1:0]            s_axis_tready,
  output logic [NUM_SOCKETS-1:0]            o_grant,
  output logic [NUM_SOCKETS-1:0]            o_done,
  output logic                              o_busy,
  output logic [31:0]                       o_seq_number,
  output logic [31:0]                       o_ack_number,
  output logic [15:0]                       o_source_port,
  output logic [15:0]                       o_dest_port,
  output logic [7:0]                        o_flags,
  output logic [15:0]                       o_window_size,
  output logic [31:0]                       o_dst_ip,
  output logic                              o_hdr_valid,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [1:0]                        dbg_state
);

  localparam int IW = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [NUM_SOCKETS-1:0] ONE_HOT0 = NUM_SOCKETS'(1);

  // AXIS handshake: a payload beat moves when the granted socket's tvalid and the
  // generator's tready are both high in DATA; tready is never a function of tvalid.
  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          has_pl;
  logic          found;
  logic [IW-1:0] winner;
  logic          last_beat;

`ifdef TCP_TX_ARB_STRICT_PRIO_EN
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_SOCKETS; i++) begin
      if (!found && i_req[i]) begin
        found  = 1'b1;
        winner = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr;
  int            cand;

  // Search begins at the pointer and wraps, so the last served socket goes to the back.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int i = 0; i < NUM_SOCKETS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_SOCKETS) cand = cand - NUM_SOCKETS;
      if (!found && i_req[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end
`endif

  assign last_beat = s_axis_tvalid[idx] && m_axis_tready && s_axis_tlast[idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      has_pl        <= 1'b0;
      o_grant       <= '0;
      o_seq_number  <= '0;
      o_ack_number  <= '0;
      o_source_port <= '0;
      o_dest_port   <= '0;
      o_flags       <= '0;
      o_window_size <= '0;
      o_dst_ip      <= '0;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
      ptr           <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            o_seq_number  <= i_seq_number[32*winner +: 32];
            o_ack_number  <= i_ack_number[32*winner +: 32];
            o_source_port <= i_source_port[16*winner +: 16];
            o_dest_port   <= i_dest_port[16*winner +: 16];
            o_flags       <= i_flags[8*winner +: 8];
            o_window_size <= i_window_size[16*winner +: 16];
            o_dst_ip      <= i_dst_ip[32*winner +: 32];
            o_grant       <= ONE_HOT0 << winner;
            idx           <= winner;
            has_pl        <= i_has_payload[winner];
            state         <= ST_HDR;
          end
        end
        ST_HDR:  state <= has_pl ? ST_DATA : ST_DONE;
        ST_DATA: if (last_beat) state <= ST_DONE;
        ST_DONE: begin
          o_grant <= '0;
`ifndef TCP_TX_ARB_STRICT_PRIO_EN
          ptr <= (idx == IW'(NUM_SOCKETS - 1)) ? '0 : idx + 1'b1;
`endif
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = '0;
    o_done        = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state == ST_DATA) begin
      m_axis_tdata       = s_axis_tdata[DATA_WIDTH*idx +: DATA_WIDTH];
      m_axis_tvalid      = s_axis_tvalid[idx];
      m_axis_tlast       = s_axis_tlast[idx];
      s_axis_tready[idx] = m_axis_tready;
    end
    if (state == ST_DONE) o_done[idx] = 1'b1;
  end

  assign o_busy      = (state != ST_IDLE);
  assign o_hdr_valid = (state == ST_HDR);
  assign dbg_state   = state;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: single segment, header-only, backpressure/latch, reset, contention.
module tb_tcp_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req, has_payload;
  logic [32*N-1:0] seq_number, ack_number, dst_ip;
  logic [16*N-1:0] source_port, dest_port, window_size;
  logic [8*N-1:0]  flags;
  logic [DW*N-1:0] s_tdata;
  logic [N-1:0]    s_tvalid, s_tlast, s_tready;
  logic [N-1:0]    grant, done;
  logic            busy, hdr_valid;
  logic [31:0]     o_seq, o_ack, o_dip;
  logic [15:0]     o_sport, o_dport, o_win;
  logic [7:0]      o_flg;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, m_tready;
  logic [1:0]      dbg_state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  tcp_tx_arbiter #(.NUM_SOCKETS(N), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_has_payload(has_payload),
    .i_seq_number(seq_number), .i_ack_number(ack_number),
    .i_source_port(source_port), .i_dest_port(dest_port), .i_flags(flags),
    .i_window_size(window_size), .i_dst_ip(dst_ip),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready), .o_grant(grant), .o_done(done), .o_busy(busy),
    .o_seq_number(o_seq), .o_ack_number(o_ack), .o_source_port(o_sport),
    .o_dest_port(o_dport), .o_flags(o_flg), .o_window_size(o_win), .o_dst_ip(o_dip),
    .o_hdr_valid(hdr_valid), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_hdr(input int k, input logic [31:0] seq, input logic [7:0] flg,
                         input logic hp);
    seq_number[32*k +: 32]  = seq;
    ack_number[32*k +: 32]  = seq ^ 32'h0F0F_0F0F;
    source_port[16*k +: 16] = 16'h1000 + 16'(k);
    dest_port[16*k +: 16]   = 16'd80;
    flags[8*k +: 8]         = flg;
    window_size[16*k +: 16] = 16'hFFF0;
    dst_ip[32*k +: 32]      = 32'hC0A8_0000 + 32'(k);
    has_payload[k]          = hp;
  endtask

  task automatic set_beat(input int k, input logic [7:0] d, input logic v, input logic l);
    s_tdata[DW*k +: DW] = d;
    s_tvalid[k]         = v;
    s_tlast[k]          = l;
  endtask

  initial begin
    logic tr_pat [5];
    int   beat;
    int   exp_k;

    rst = 1'b1; req = '0; has_payload = '0; seq_number = '0; ack_number = '0;
    dst_ip = '0; source_port = '0; dest_port = '0; window_size = '0; flags = '0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_hdr_valid", 64'(hdr_valid), 0);
    chk("rst_seq", 64'(o_seq), 0);
    chk("rst_m_tvalid", 64'(m_tvalid), 0);
    chk("rst_s_tready", 64'(s_tready), 0);

    // single request on socket 2, 4-byte payload
    set_hdr(2, 32'h1000_0001, 8'h18, 1'b1);
    set_beat(2, 8'hA0, 1'b1, 1'b0);
    req = 4'b0100;
    #1;
    chk("s2_idle_grant", 64'(grant), 0);
    chk("s2_idle_m_tvalid", 64'(m_tvalid), 0);
    tick();
    chk("s2_grant", 64'(grant), 64'b0100);
    chk("s2_hdr_valid", 64'(hdr_valid), 1);
    chk("s2_seq", 64'(o_seq), 64'h1000_0001);
    chk("s2_flags", 64'(o_flg), 64'h18);
    chk("s2_sport", 64'(o_sport), 64'h1002);
    chk("s2_hdr_s_tready", 64'(s_tready), 0);
    req = '0;
    tick();
    for (int b = 0; b < 4; b++) begin
      set_beat(2, 8'(8'hA0 + b), 1'b1, b == 3);
      #1;
      chk("s2_m_tdata", 64'(m_tdata), 64'(8'hA0 + b));
      chk("s2_m_tlast", 64'(m_tlast), 64'(b == 3));
      chk("s2_s_tready", 64'(s_tready), 64'b0100);
      chk("s2_hdr_valid_low", 64'(hdr_valid), 0);
      tick();
    end
    set_beat(2, 8'h00, 1'b0, 1'b0);
    #1;
    chk("s2_done", 64'(done), 64'b0100);
    chk("s2_done_m_tvalid", 64'(m_tvalid), 0);
    tick();
    chk("s2_idle_busy", 64'(busy), 0);
    chk("s2_idle_grant_clr", 64'(grant), 0);
    chk("s2_idle_done_clr", 64'(done), 0);
    chk("s2_seq_hold", 64'(o_seq), 64'h1000_0001);

    // header-only segment on socket 0, stray payload valid must not leak
    set_hdr(0, 32'h0000_0A0A, 8'h10, 1'b0);
    set_beat(0, 8'h55, 1'b1, 1'b1);
    req = 4'b0001;
    tick();
    chk("h0_grant", 64'(grant), 64'b0001);
    chk("h0_hdr_valid", 64'(hdr_valid), 1);
    chk("h0_flags", 64'(o_flg), 64'h10);
    chk("h0_m_tvalid_hdr", 64'(m_tvalid), 0);
    req = '0;
    tick();
    chk("h0_done", 64'(done), 64'b0001);
    chk("h0_m_tvalid_done", 64'(m_tvalid), 0);
    chk("h0_hdr_valid_low", 64'(hdr_valid), 0);
    tick();
    chk("h0_idle_busy", 64'(busy), 0);
    set_beat(0, 8'h00, 1'b0, 1'b0);

    // socket 1: 3-beat payload under backpressure, seq changed after grant
    tr_pat[0] = 1'b1; tr_pat[1] = 1'b0; tr_pat[2] = 1'b0; tr_pat[3] = 1'b1; tr_pat[4] = 1'b1;
    set_hdr(1, 32'h1234_5678, 8'h18, 1'b1);
    req = 4'b0010;
    tick();
    chk("bp_grant", 64'(grant), 64'b0010);
    set_hdr(1, 32'hDEAD_BEEF, 8'h18, 1'b1);
    #1;
    chk("latch_seq_hdr", 64'(o_seq), 64'h1234_5678);
    tick();
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      m_tready = tr_pat[c];
      set_beat(1, 8'(8'hB0 + beat), 1'b1, beat == 2);
      #1;
      chk("bp_m_tdata", 64'(m_tdata), 64'(8'hB0 + beat));
      chk("bp_s_tready", 64'(s_tready), tr_pat[c] ? 64'b0010 : 64'b0000);
      chk("bp_busy", 64'(busy), 1);
      tick();
      if (tr_pat[c]) beat++;
    end
    set_beat(1, 8'h00, 1'b0, 1'b0);
    m_tready = 1'b1;
    #1;
    chk("bp_done", 64'(done), 64'b0010);
    chk("latch_seq_done", 64'(o_seq), 64'h1234_5678);
    req = '0;
    tick();

    // reset after 2 of 5 beats on socket 3
    set_hdr(3, 32'h3333_0003, 8'h18, 1'b1);
    set_beat(3, 8'hC0, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    chk("r3_grant", 64'(grant), 64'b1000);
    req = '0;
    tick();
    chk("r3_beat0", 64'(m_tdata), 64'hC0);
    set_beat(3, 8'hC1, 1'b1, 1'b0);
    tick();
    set_beat(3, 8'hC2, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("r3_mid_tvalid", 64'(m_tvalid), 1);
    tick();
    chk("r3_rst_grant", 64'(grant), 0);
    chk("r3_rst_busy", 64'(busy), 0);
    chk("r3_rst_seq", 64'(o_seq), 0);
    chk("r3_rst_m_tvalid", 64'(m_tvalid), 0);
    chk("r3_rst_s_tready", 64'(s_tready), 0);
    chk("r3_rst_done", 64'(done), 0);
    rst = 1'b0;
    set_beat(3, 8'h00, 1'b0, 1'b0);

    // contention: all sockets request header-only segments continuously
    for (int k = 0; k < N; k++) set_hdr(k, 32'(32'h5000_0000 + k), 8'h10, 1'b0);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
`ifdef TCP_TX_ARB_STRICT_PRIO_EN
      exp_k = 0;
`else
      exp_k = g % N;
`endif
      tick();
      chk("cont_grant", 64'(grant), 64'(1) << exp_k);
      chk("cont_seq", 64'(o_seq), 64'(32'h5000_0000 + exp_k));
      tick();
      chk("cont_done", 64'(done), 64'(1) << exp_k);
      tick();
    end
    req = '0;
    tick();
    chk("end_busy", 64'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
